// File: rtl/cisr_row_len_buffer_pkg.sv
// -----------------------------------------------------------------------------
// cisr_pkg
// Shared definitions for the CISR row-length path.
//   DIM_W      : width of matrix dimension counters (row counts, row indices).
//                Mirrors the value used by the DCP mock environment.
//   ROW_LEN_W  : default width of one row-length entry.
//   row_len_t  : one row-length entry.
//   ptr_w()    : pointer width for a power-of-two circular buffer.
// -----------------------------------------------------------------------------
package cisr_pkg;

  localparam int DIM_W     = 32;
  localparam int ROW_LEN_W = 32;

  typedef logic [ROW_LEN_W-1:0] row_len_t;

  // A depth of 1 still needs a 1-bit pointer so the vectors stay legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cisr_row_len_buffer_if.sv
// -----------------------------------------------------------------------------
// cisr_row_len_buffer_if
// Bus bundle between the memory-side row-length stream, the row-length buffer
// and the decoder channels.
//   in_valid/in_data/in_ready : row-length stream. A beat transfers on a
//     clock edge where in_valid && in_ready. in_ready depends on registered
//     buffer state only, so the producer may look at it before deciding
//     in_valid; in_valid must not wait on in_ready.
//   row_len_pop[NUM_CH] : per-channel request, decoder -> buffer
//   row_len[NUM_CH]     : per-channel served length, buffer -> decoder
//   pipe_bubble[NUM_CH] : per-channel "request not served this cycle"
// master = producer/decoder side, slave = buffer.
// -----------------------------------------------------------------------------
interface cisr_row_len_buffer_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic [NUM_CH-1:0] row_len_pop;
  logic [DATA_W-1:0] row_len [NUM_CH];
  logic [NUM_CH-1:0] pipe_bubble;

  modport master (
    output in_valid, in_data, row_len_pop,
    input  in_ready, row_len, pipe_bubble
  );

  modport slave (
    input  in_valid, in_data, row_len_pop,
    output in_ready, row_len, pipe_bubble
  );

endinterface

// File: rtl/cisr_row_len_buffer_prefix_count.sv
// -----------------------------------------------------------------------------
// cisr_prefix_count
// Combinational exclusive prefix popcount.
//   bits[N]   : input vector
//   rank[k]   : number of set bits[j] with j < k
//   total     : number of set bits overall
// W must be able to hold N.
// -----------------------------------------------------------------------------
module cisr_prefix_count #(
  parameter int N = 16,
  parameter int W = $clog2(N) + 1
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] rank [N],
  output logic [W-1:0] total
);

  logic [W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      rank[k] = acc;
      acc     = acc + W'(bits[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/cisr_row_len_buffer.sv
// -----------------------------------------------------------------------------
// cisr_row_len_buffer
// Shared row-length FIFO feeding the decoder channels. Accepts one row length
// per beat and hands out up to NUM_CH entries per cycle, oldest entry to the
// lowest-indexed requesting channel. Requesters that cannot be served (or any
// channel during a stall) see pipe_bubble.
//
// Parameters: NUM_CH (channels), DATA_W (row-length width),
//             DEPTH (entries, power of two, >= NUM_CH)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   spmv_init    : synchronous flush; latches num_rows for the new matrix
//   num_rows     : total rows of the matrix (sampled on spmv_init)
//   stall        : global downstream stall, blocks all serving
//   done         : all num_rows lengths have been issued since the last init
//   bus (slave)  : in_valid/in_data/in_ready stream, row_len_pop requests,
//                  row_len and pipe_bubble per channel
//   bubble_cycles: only with CISR_RLB_STATS_EN defined; saturating count of
//                  non-stalled cycles with at least one bubbled channel
//
// Optional feature macro: CISR_RLB_STATS_EN
// -----------------------------------------------------------------------------
module cisr_row_len_buffer
  import cisr_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = ROW_LEN_W,
  parameter int DEPTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spmv_init,
  input  logic [DIM_W-1:0] num_rows,
  input  logic             stall,
  output logic             done,
`ifdef CISR_RLB_STATS_EN
  output logic [31:0]      bubble_cycles,
`endif
  cisr_row_len_buffer_if.slave bus
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RANK_W = $clog2(NUM_CH) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DIM_W-1:0]  accepted;
  logic [DIM_W-1:0]  issued;
  logic [DIM_W-1:0]  rows_q;
  // Distinguishes "never initialised" from "init with zero rows": done may
  // only rise after an init.
  logic              armed;

  // ---------------------------------------------------------------------------
  // Request ranking
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] req;
  logic [RANK_W-1:0] rank [NUM_CH];
  logic [RANK_W-1:0] req_total;
  logic [NUM_CH-1:0] has_entry;
  logic [CNT_W-1:0]  issued_n;
  logic [DIM_W-1:0]  issued_next;
  logic              wr;

  assign req = bus.row_len_pop & {NUM_CH{~stall}};

  cisr_prefix_count #(
    .N (NUM_CH),
    .W (RANK_W)
  ) u_prefix_count (
    .bits  (req),
    .rank  (rank),
    .total (req_total)
  );

  // A channel's rank is its offset from the read pointer; it has data only
  // when that offset lies inside the occupied region. Since DEPTH >= NUM_CH
  // the rank always fits in the count width.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      has_entry[k]       = (CNT_W'(rank[k]) < count);
      bus.row_len[k]     = (req[k] && has_entry[k]) ? mem[rd_ptr + PTR_W'(rank[k])] : '0;
      bus.pipe_bubble[k] = stall || (bus.row_len_pop[k] && !has_entry[k]);
    end
  end

  // Served requesters are always a prefix of the ranked requesters, so the
  // number issued is simply the smaller of demand and occupancy.
  assign issued_n    = (CNT_W'(req_total) < count) ? CNT_W'(req_total) : count;
  assign issued_next = issued + DIM_W'(issued_n);

  // Registered-state-only: freeing entries this cycle does not open in_ready.
  assign bus.in_ready = (count < CNT_W'(DEPTH)) && (accepted < rows_q) && !done;
  assign wr           = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      accepted <= '0;
      issued   <= '0;
      rows_q   <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
    end else if (spmv_init) begin
      // Flush wins over any write or issue in the same cycle.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      accepted <= '0;
      issued   <= '0;
      rows_q   <= num_rows;
      armed    <= 1'b1;
      done     <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + PTR_W'(issued_n);
      wr_ptr   <= wr_ptr + PTR_W'(wr);
      count    <= count + CNT_W'(wr) - issued_n;
      accepted <= accepted + DIM_W'(wr);
      issued   <= issued_next;
      if (armed && (issued_next == rows_q)) begin
        done <= 1'b1;
      end
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr && !spmv_init) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

`ifdef CISR_RLB_STATS_EN
  // ---------------------------------------------------------------------------
  // Bubble statistics
  // ---------------------------------------------------------------------------
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (spmv_init) begin
      bubble_cnt <= '0;
    end else if (!stall && (|bus.pipe_bubble) && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign bubble_cycles = bubble_cnt;
`endif

endmodule

// File: tb/tb_cisr_row_len_buffer.sv
`timescale 1ns/1ps
module tb_cisr_row_len_buffer;
  import cisr_pkg::*;

  localparam int NUM_CH = 16;
  localparam int DATA_W = ROW_LEN_W;
  localparam int DEPTH  = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             spmv_init = 1'b0;
  logic [DIM_W-1:0] num_rows = '0;
  logic             stall = 1'b0;
  logic             done;
`ifdef CISR_RLB_STATS_EN
  logic [31:0]      bubble_cycles;
`endif

  cisr_row_len_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  cisr_row_len_buffer #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spmv_init     (spmv_init),
    .num_rows      (num_rows),
    .stall         (stall),
    .done          (done),
`ifdef CISR_RLB_STATS_EN
    .bubble_cycles (bubble_cycles),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: a queue of buffered lengths plus row bookkeeping
  // ---------------------------------------------------------------------------
  row_len_t          exp_q[$];
  int                m_rows, m_acc, m_iss;
  bit                m_done, m_armed;
  row_len_t          exp_len [NUM_CH];
  logic [NUM_CH-1:0] exp_bubble;
  logic              exp_ready;
  int                n_serve;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic model_reset();
    exp_q.delete();
    m_rows = 0; m_acc = 0; m_iss = 0; m_done = 0; m_armed = 0;
  endtask

  // Expected outputs for the inputs currently driven.
  task automatic model_expect();
    int idx;
    idx = 0;
    exp_ready = (exp_q.size() < DEPTH) && (m_acc < m_rows) && !m_done;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_len[k]    = '0;
      exp_bubble[k] = stall;
      if (!stall && bus.row_len_pop[k]) begin
        if (idx < exp_q.size()) begin
          exp_len[k] = exp_q[idx];
          idx++;
        end else begin
          exp_bubble[k] = 1'b1;
        end
      end
    end
    n_serve = idx;
  endtask

  // State update at a clock edge, using the expectation computed before it.
  task automatic model_advance();
    bit push;
    if (spmv_init) begin
      exp_q.delete();
      m_rows = int'(num_rows); m_acc = 0; m_iss = 0; m_done = 0; m_armed = 1;
    end else begin
      push = bus.in_valid && exp_ready;
      repeat (n_serve) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(bus.in_data);
        m_acc++;
      end
      m_iss += n_serve;
      if (m_armed && m_iss == m_rows) m_done = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    spmv_init = 1'b0; stall = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.row_len_pop = '0;
  endtask

  task automatic do_init(input int rows);
    drive_idle();
    spmv_init = 1'b1;
    num_rows  = DIM_W'(rows);
    model_expect();
    tick();
    spmv_init = 1'b0;
  endtask

  task automatic write_beat(input row_len_t v);
    bus.in_valid = 1'b1; bus.in_data = v; bus.row_len_pop = '0;
    model_expect();
    tick();
    bus.in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [NUM_CH-1:0] pop_v;
    drive_idle();
    model_reset();
    pop_v = NUM_CH'($urandom);
    bus.row_len_pop = pop_v;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset done: got %b want 0", done);
    end
    n_checks++;
    if (bus.pipe_bubble !== pop_v) begin
      n_fail++; $display("FAIL reset bubble: got %h want %h", bus.pipe_bubble, pop_v);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      n_checks++;
      if (bus.row_len[k] !== '0) begin
        n_fail++; $display("FAIL reset row_len[%0d]: got %h want 0", k, bus.row_len[k]);
      end
    end
    stall = 1'b1;
    #1;
    n_checks++;
    if (bus.pipe_bubble !== '1) begin
      n_fail++; $display("FAIL reset stall bubble: got %h want all ones", bus.pipe_bubble);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    model_expect(); tick();
    model_expect(); tick();
    // Without an init, done must not rise even though issued == rows_q == 0.
    n_checks++;
    if (done !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset idle: done=%b in_ready=%b want 0 0", done, bus.in_ready);
    end
  endtask

  task automatic test_basic_serve();
    row_len_t vals [4];
    vals = '{32'd3, 32'd1, 32'd4, 32'd1};
    do_init(4);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vals[i]; bus.row_len_pop = '0;
      model_expect();
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL basic in_ready beat %0d: got %b want 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.row_len_pop = '1;
    model_expect();
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      n_checks++;
      if (bus.row_len[k] !== ((k < 4) ? vals[k] : row_len_t'(0))) begin
        n_fail++; $display("FAIL basic row_len[%0d]: got %0d want %0d", k, bus.row_len[k],
                           (k < 4) ? vals[k] : row_len_t'(0));
      end
    end
    n_checks++;
    if (bus.pipe_bubble !== 16'hfff0) begin
      n_fail++; $display("FAIL basic bubble: got %h want fff0", bus.pipe_bubble);
    end
    tick();
    bus.row_len_pop = '0;
    #1;
    n_checks++;
    if (done !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic done: done=%b in_ready=%b want 1 0", done, bus.in_ready);
    end
    model_expect(); tick();
  endtask

  task automatic test_sparse();
    do_init(10);
    write_beat(32'd7);
    write_beat(32'd9);
    bus.row_len_pop = 16'h0224;
    model_expect();
    #1;
    n_checks++;
    if (bus.row_len[2] !== 32'd7 || bus.row_len[5] !== 32'd9 || bus.row_len[9] !== 32'd0) begin
      n_fail++; $display("FAIL sparse data: ch2=%0d ch5=%0d ch9=%0d want 7 9 0",
                         bus.row_len[2], bus.row_len[5], bus.row_len[9]);
    end
    n_checks++;
    if (bus.pipe_bubble !== 16'h0200) begin
      n_fail++; $display("FAIL sparse bubble: got %h want 0200", bus.pipe_bubble);
    end
    tick();
    bus.row_len_pop = 16'h0001;
    model_expect();
    #1;
    n_checks++;
    if (bus.pipe_bubble !== 16'h0001 || bus.row_len[0] !== 32'd0) begin
      n_fail++; $display("FAIL sparse empty: bubble=%h ch0=%0d want 0001 0",
                         bus.pipe_bubble, bus.row_len[0]);
    end
    tick();
    bus.row_len_pop = '0;
  endtask

  task automatic test_stall();
    row_len_t vals [5];
    do_init(20);
    for (int i = 0; i < 5; i++) begin
      vals[i] = row_len_t'($urandom);
      write_beat(vals[i]);
    end
    stall = 1'b1;
    bus.row_len_pop = '1;
    for (int c = 0; c < 2; c++) begin
      model_expect();
      #1;
      n_checks++;
      if (bus.pipe_bubble !== '1 || bus.row_len[0] !== '0) begin
        n_fail++; $display("FAIL stall cycle %0d: bubble=%h ch0=%h want all ones 0",
                           c, bus.pipe_bubble, bus.row_len[0]);
      end
      tick();
    end
    stall = 1'b0;
    model_expect();
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus.row_len[k] !== ((k < 5) ? vals[k] : row_len_t'(0))) begin
        n_fail++; $display("FAIL stall resume row_len[%0d]: got %h want %h", k, bus.row_len[k],
                           (k < 5) ? vals[k] : row_len_t'(0));
      end
    end
    n_checks++;
    if (bus.pipe_bubble !== 16'hffe0) begin
      n_fail++; $display("FAIL stall resume bubble: got %h want ffe0", bus.pipe_bubble);
    end
    tick();
    bus.row_len_pop = '0;
  endtask

  task automatic test_wrap();
    int fed, srv;
    fed = 0; srv = 0;
    do_init(100);
    for (int i = 0; i < DEPTH; i++) begin
      write_beat(row_len_t'(1000 + fed));
      fed++;
    end
    // Full, while the same cycle frees 16 entries: in_ready must stay low.
    bus.in_valid = 1'b1; bus.in_data = row_len_t'(1000 + fed); bus.row_len_pop = '1;
    model_expect();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL wrap full in_ready: got %b want 0", bus.in_ready);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      n_checks++;
      if (bus.row_len[k] !== row_len_t'(1000 + k)) begin
        n_fail++; $display("FAIL wrap first serve ch%0d: got %0d want %0d", k, bus.row_len[k], 1000 + k);
      end
    end
    srv = NUM_CH;
    tick();
    for (int c = 0; c < 70; c++) begin
      bus.in_valid    = (fed < 52);
      bus.in_data     = row_len_t'(1000 + fed);
      bus.row_len_pop = NUM_CH'($urandom);
      model_expect();
      #1;
      n_checks++;
      if (bus.in_ready !== exp_ready || bus.pipe_bubble !== exp_bubble || done !== m_done) begin
        n_fail++; $display("FAIL wrap ctl cycle %0d: in_ready=%b bubble=%h done=%b want %b %h %b",
                           c, bus.in_ready, bus.pipe_bubble, done, exp_ready, exp_bubble, m_done);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        n_checks++;
        if (bus.row_len[k] !== exp_len[k]) begin
          n_fail++; $display("FAIL wrap row_len[%0d] cycle %0d: got %0d want %0d",
                             k, c, bus.row_len[k], exp_len[k]);
        end
        if (bus.row_len_pop[k] && !exp_bubble[k]) begin
          n_checks++;
          if (bus.row_len[k] !== row_len_t'(1000 + srv)) begin
            n_fail++; $display("FAIL wrap order ch%0d: got %0d want %0d", k, bus.row_len[k], 1000 + srv);
          end
          srv++;
        end
      end
      if (bus.in_valid && exp_ready) fed++;
      tick();
    end
    n_checks++;
    if (srv != 52) begin
      n_fail++; $display("FAIL wrap drained: served %0d want 52", srv);
    end
    drive_idle();
  endtask

  task automatic test_flush();
    do_init(50);
    write_beat(32'd11);
    write_beat(32'd12);
    write_beat(32'd13);
    spmv_init = 1'b1; num_rows = DIM_W'(7);
    bus.in_valid = 1'b1; bus.in_data = 32'd77; bus.row_len_pop = '1;
    model_expect();
    tick();
    spmv_init = 1'b0; bus.in_valid = 1'b0;
    model_expect();
    #1;
    n_checks++;
    if (bus.pipe_bubble !== '1 || bus.row_len[0] !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush empty: bubble=%h ch0=%0d in_ready=%b want all ones 0 1",
                         bus.pipe_bubble, bus.row_len[0], bus.in_ready);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = row_len_t'(200 + i); bus.row_len_pop = '0;
      model_expect();
      #1;
      n_checks++;
      if (bus.in_ready !== (i < 7)) begin
        n_fail++; $display("FAIL flush rows_q beat %0d: in_ready=%b want %b", i, bus.in_ready, (i < 7));
      end
      tick();
    end
    bus.in_valid = 1'b0; bus.row_len_pop = '1;
    model_expect();
    #1;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (bus.row_len[k] !== row_len_t'(200 + k)) begin
        n_fail++; $display("FAIL flush data ch%0d: got %0d want %0d", k, bus.row_len[k], 200 + k);
      end
    end
    n_checks++;
    if (bus.pipe_bubble !== 16'hff80) begin
      n_fail++; $display("FAIL flush bubble: got %h want ff80", bus.pipe_bubble);
    end
    tick();
    bus.row_len_pop = '0;
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL flush done: got %b want 1", done);
    end
  endtask

  task automatic test_async_reset();
    do_init(30);
    write_beat(32'd5);
    write_beat(32'd6);
    bus.row_len_pop = '1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.row_len[0] !== 32'd5) begin
      n_fail++; $display("FAIL areset before: in_ready=%b ch0=%0d want 1 5", bus.in_ready, bus.row_len[0]);
    end
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.pipe_bubble !== '1 || bus.row_len[0] !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL areset immediate: in_ready=%b bubble=%h ch0=%0d done=%b want 0 all ones 0 0",
                         bus.in_ready, bus.pipe_bubble, bus.row_len[0], done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    model_expect(); tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL areset after: in_ready=%b done=%b want 0 0", bus.in_ready, done);
    end
  endtask

  task automatic test_random();
    int rows;
    rows = $urandom_range(40, 90);
    do_init(rows);
    for (int c = 0; c < 800; c++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_data     = row_len_t'($urandom);
      stall           = ($urandom_range(0, 9) == 0);
      bus.row_len_pop = NUM_CH'($urandom);
      model_expect();
      #1;
      n_checks++;
      if (bus.in_ready !== exp_ready || bus.pipe_bubble !== exp_bubble || done !== m_done) begin
        n_fail++; $display("FAIL random ctl cycle %0d: in_ready=%b bubble=%h done=%b want %b %h %b",
                           c, bus.in_ready, bus.pipe_bubble, done, exp_ready, exp_bubble, m_done);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        n_checks++;
        if (bus.row_len[k] !== exp_len[k]) begin
          n_fail++; $display("FAIL random row_len[%0d] cycle %0d: got %h want %h",
                             k, c, bus.row_len[k], exp_len[k]);
        end
      end
      tick();
      if (m_done) break;
    end
    drive_idle();
    #1;
    n_checks++;
    if (done !== 1'b1 || !m_done) begin
      n_fail++; $display("FAIL random completion: done=%b model_done=%b want 1 1", done, m_done);
    end
  endtask

`ifdef CISR_RLB_STATS_EN
  task automatic test_stats();
    do_init(100);
    for (int c = 0; c < 3; c++) begin
      bus.row_len_pop = 16'h0001; stall = 1'b0;
      model_expect(); tick();
    end
    for (int c = 0; c < 2; c++) begin
      bus.row_len_pop = '0; stall = 1'b1;
      model_expect(); tick();
    end
    drive_idle();
    model_expect(); tick();
    n_checks++;
    if (bubble_cycles !== 32'd3) begin
      n_fail++; $display("FAIL stats bubble_cycles: got %0d want 3", bubble_cycles);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic_serve();
    test_sparse();
    test_stall();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
`ifdef CISR_RLB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
